// File: rtl/log_operand_encoder.sv
// Two-stage leading-one / mantissa encoder for the log multiplier.
// Define LOG_ENC_ROUND_EN for round-half-up fraction with K carry.
module log_operand_encoder #(
  parameter int DataIN_width     = 16,
  parameter int DataK_width      = 4,
  parameter int truncation_width = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DataIN_width-1:0]     in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DataK_width-1:0]      out_k,
  output logic [truncation_width:0]   out_x,
  output logic                        out_zero
);

  localparam int XW = truncation_width + 1;

  logic                    r_s1_valid;
  logic [DataIN_width-1:0] r_s1_data;
  logic [DataK_width-1:0]  r_s1_k;
  logic                    r_s1_zero;

  logic                    r_s2_valid;
  logic [DataK_width-1:0]  r_k;
  logic [XW-1:0]           r_x;
  logic                    r_zero;

  logic                    w_s2_adv;
  logic [DataK_width-1:0]  w_k;
  logic                    w_zero;
  logic [DataIN_width-1:0] w_sh;
  logic [XW-1:0]           w_xt;
  logic [XW-1:0]           w_x;
  logic [DataK_width-1:0]  w_kn;
  logic                    w_unused;

  assign w_s2_adv = !r_s2_valid | out_ready;
  assign in_ready = !r_s1_valid | !r_s2_valid | out_ready;

  always_comb begin
    w_k = '0;
    for (int i = 0; i < DataIN_width; i++)
      if (in_data[i]) w_k = DataK_width'(i);
  end

  assign w_zero = ~|in_data;

  // Width is a power of two, so ~K equals (width-1-K)
  assign w_sh     = r_s1_data << ~r_s1_k;
  assign w_xt     = w_sh[DataIN_width-2 -: XW];
  assign w_unused = ^w_sh;

`ifdef LOG_ENC_ROUND_EN
  logic          w_rb;
  logic [XW:0]   w_sum;

  assign w_rb  = w_sh[DataIN_width-2-XW];
  assign w_sum = {1'b0, w_xt} + {{XW{1'b0}}, w_rb};

  always_comb begin
    w_x  = w_sum[XW-1:0];
    w_kn = r_s1_k;
    if (w_sum[XW]) begin
      if (&r_s1_k) begin
        w_x = '1;
      end else begin
        w_x  = '0;
        w_kn = r_s1_k + DataK_width'(1);
      end
    end
  end
`else
  assign w_x  = w_xt;
  assign w_kn = r_s1_k;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_k     <= '0;
      r_s1_zero  <= 1'b0;
      r_s2_valid <= 1'b0;
      r_k        <= '0;
      r_x        <= '0;
      r_zero     <= 1'b0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_data <= in_data;
          r_s1_k    <= w_k;
          r_s1_zero <= w_zero;
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_k    <= w_kn;
          r_x    <= w_x;
          r_zero <= r_s1_zero;
        end
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_k     = r_k;
  assign out_x     = r_x;
  assign out_zero  = r_zero;

endmodule

// File: tb/tb_log_operand_encoder.sv
// Scoreboard bench for log_operand_encoder.
// Directed vectors plus a model-checked random stream.
module tb_log_operand_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_k;
  logic [6:0]  out_x;
  logic        out_zero;

  int checks = 0;
  int errors = 0;
  int nres   = 0;
  logic [11:0] q[$];

  always #5 clk = ~clk;

  log_operand_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_k(out_k), .out_x(out_x), .out_zero(out_zero)
  );

  function automatic logic [11:0] ev(input int k, input int x, input bit z);
    return {4'(k), 7'(x), z};
  endfunction

  function automatic logic [11:0] model(input logic [15:0] d);
    int k;
    longint frac, x;
    if (d == 16'h0) return ev(0, 0, 1'b1);
    k = 15;
    while (!d[k]) k--;
    frac = longint'(d) - (longint'(1) << k);
`ifdef LOG_ENC_ROUND_EN
    x = (((frac << 8) >> k) + 1) >> 1;
    if (x == 128) begin
      if (k == 15) x = 127;
      else begin k++; x = 0; end
    end
`else
    x = (frac << 7) >> k;
`endif
    return ev(k, int'(x), 1'b0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      nres++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h expected none",
                 {out_k, out_x, out_zero});
      end else begin
        chk("result", 32'({out_k, out_x, out_zero}), 32'(q.pop_front()));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after acceptance edge.
  task automatic send(input logic [15:0] d, input logic [11:0] e);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    else q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
  endtask

  logic [15:0] dir_d [5] = '{16'h0001, 16'h00B4, 16'h0000,
                             16'h01FF, 16'hFFFF};
  logic [11:0] dir_e [5];
  int base;

  initial begin
    dir_e[0] = ev(0, 7'h00, 1'b0);
    dir_e[1] = ev(7, 7'h34, 1'b0);
    dir_e[2] = ev(0, 7'h00, 1'b1);
`ifdef LOG_ENC_ROUND_EN
    dir_e[3] = ev(9, 7'h00, 1'b0);
`else
    dir_e[3] = ev(8, 7'h7F, 1'b0);
`endif
    dir_e[4] = ev(15, 7'h7F, 1'b0);

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_kxz", 32'({out_k, out_x, out_zero}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // latency
    send(16'h0001, dir_e[0]);
    @(negedge clk);
    chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    drain();

    for (int i = 1; i < 5; i++) send(dir_d[i], dir_e[i]);
    drain();

    // back-pressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0010;
    @(negedge clk);
    chk("bp_acc1", 32'(in_ready), 32'd1);
    q.push_back(ev(4, 0, 1'b0));
    @(posedge clk); #1;
    in_data = 16'h0100;
    @(negedge clk);
    chk("bp_acc2", 32'(in_ready), 32'd1);
    q.push_back(ev(8, 0, 1'b0));
    @(posedge clk); #1;
    in_data = 16'h1000;
    repeat (2) begin
      @(negedge clk);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_k", 32'(out_k), 32'd4);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_acc3", 32'(in_ready), 32'd1);
    q.push_back(ev(12, 0, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // full-rate random stream
    base = nres;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 16'($urandom >> $urandom_range(0, 16));
      @(negedge clk);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      if (in_ready) q.push_back(model(in_data));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    chk("stream_count", 32'(nres - base), 32'd20);

    // reset with both stages full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0F0F;
    @(posedge clk); #1;
    in_data = 16'h00FF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_full", 32'({out_valid, in_ready}), 32'b10);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    base = nres;
    send(16'h0004, ev(2, 0, 1'b0));
    drain();
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_count", 32'(nres - base), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
